c499: RTL and testbench



---
 rtl/c499.sv | 205 ++++++++++++++++++++
 tb/tb_c499.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/c499.sv
// c499: single-error-correcting decoder for 32 data bits and 8 check bits, registered Q.
// Define C499_INREG_EN to add an input register stage on D/C/E (latency 2 instead of 1).
module c499 (
  input  logic clk_i,
  input  logic srst_i,
  input  logic N1,
  input  logic N5,
  input  logic N9,
  input  logic N13,
  input  logic N17,
  input  logic N21,
  input  logic N25,
  input  logic N29,
  input  logic N33,
  input  logic N37,
  input  logic N41,
  input  logic N45,
  input  logic N49,
  input  logic N53,
  input  logic N57,
  input  logic N61,
  input  logic N65,
  input  logic N69,
  input  logic N73,
  input  logic N77,
  input  logic N81,
  input  logic N85,
  input  logic N89,
  input  logic N93,
  input  logic N97,
  input  logic N101,
  input  logic N105,
  input  logic N109,
  input  logic N113,
  input  logic N117,
  input  logic N121,
  input  logic N125,
  input  logic N129,
  input  logic N130,
  input  logic N131,
  input  logic N132,
  input  logic N133,
  input  logic N134,
  input  logic N135,
  input  logic N136,
  input  logic N137,
  output logic N724,
  output logic N725,
  output logic N726,
  output logic N727,
  output logic N728,
  output logic N729,
  output logic N730,
  output logic N731,
  output logic N732,
  output logic N733,
  output logic N734,
  output logic N735,
  output logic N736,
  output logic N737,
  output logic N738,
  output logic N739,
  output logic N740,
  output logic N741,
  output logic N742,
  output logic N743,
  output logic N744,
  output logic N745,
  output logic N746,
  output logic N747,
  output logic N748,
  output logic N749,
  output logic N750,
  output logic N751,
  output logic N752,
  output logic N753,
  output logic N754,
  output logic N755
);

  // Column of data bit i: one-hot byte index in S[3:0], bit-in-byte in S[6:4],
  // S7 set for even popcount so every column has weight >= 2.
  function automatic logic [7:0] col_f(input int i);
    logic [2:0] b;
    b = 3'(i % 8);
    col_f = 8'h00;
    for (int a = 0; a < 4; a++) begin
      if ((i / 8) == a) col_f[a] = 1'b1;
    end
    col_f[6:4] = b;
    col_f[7]   = ~(^b);
  endfunction

  function automatic logic [31:0] hrow_f(input int k);
    logic [7:0] col;
    hrow_f = 32'h0;
    for (int i = 0; i < 32; i++) begin
      col = col_f(i);
      hrow_f[i] = col[k];
    end
  endfunction

  logic [31:0] d_in;
  logic [7:0]  c_in;
  logic        e_in;

  assign d_in = {N125, N121, N117, N113, N109, N105, N101, N97,
                 N93,  N89,  N85,  N81,  N77,  N73,  N69,  N65,
                 N61,  N57,  N53,  N49,  N45,  N41,  N37,  N33,
                 N29,  N25,  N21,  N17,  N13,  N9,   N5,   N1};
  assign c_in = {N136, N135, N134, N133, N132, N131, N130, N129};
  assign e_in = N137;

  logic [31:0] d_s;
  logic [7:0]  c_s;
  logic        e_s;

`ifdef C499_INREG_EN
  logic [31:0] d_in_q;
  logic [7:0]  c_in_q;
  logic        e_in_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      d_in_q <= 32'h0;
      c_in_q <= 8'h0;
      e_in_q <= 1'b0;
    end else begin
      d_in_q <= d_in;
      c_in_q <= c_in;
      e_in_q <= e_in;
    end
  end

  assign d_s = d_in_q;
  assign c_s = c_in_q;
  assign e_s = e_in_q;
`else
  assign d_s = d_in;
  assign c_s = c_in;
  assign e_s = e_in;
`endif

  logic [7:0]  syn;
  logic [31:0] mask;
  logic [31:0] q_d;
  logic [31:0] q_q;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_syn
      localparam logic [31:0] HROW = hrow_f(gi);
      assign syn[gi] = c_s[gi] ^ (^(d_s & HROW));
    end
    // Only an exact column match flips a bit; unit-vector and stray syndromes pass data through.
    for (gi = 0; gi < 32; gi++) begin : g_mask
      localparam logic [7:0] COL = col_f(gi);
      assign mask[gi] = e_s & (syn == COL);
    end
  endgenerate

  assign q_d = d_s ^ mask;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      q_q <= 32'h0;
    end else begin
      q_q <= q_d;
    end
  end

  assign N724 = q_q[0];
  assign N725 = q_q[1];
  assign N726 = q_q[2];
  assign N727 = q_q[3];
  assign N728 = q_q[4];
  assign N729 = q_q[5];
  assign N730 = q_q[6];
  assign N731 = q_q[7];
  assign N732 = q_q[8];
  assign N733 = q_q[9];
  assign N734 = q_q[10];
  assign N735 = q_q[11];
  assign N736 = q_q[12];
  assign N737 = q_q[13];
  assign N738 = q_q[14];
  assign N739 = q_q[15];
  assign N740 = q_q[16];
  assign N741 = q_q[17];
  assign N742 = q_q[18];
  assign N743 = q_q[19];
  assign N744 = q_q[20];
  assign N745 = q_q[21];
  assign N746 = q_q[22];
  assign N747 = q_q[23];
  assign N748 = q_q[24];
  assign N749 = q_q[25];
  assign N750 = q_q[26];
  assign N751 = q_q[27];
  assign N752 = q_q[28];
  assign N753 = q_q[29];
  assign N754 = q_q[30];
  assign N755 = q_q[31];

endmodule

// File: tb/tb_c499.sv
// tb_c499: directed vectors into a scoreboard queue; a monitor pops and compares at the output latency.
module tb_c499;
`ifdef C499_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic [31:0] d = 32'h0;
  logic [7:0]  c = 8'h0;
  logic        e = 1'b0;
  logic [31:0] q;
  logic        issue_v = 1'b0;
  logic [LAT-1:0] vpipe = '0;
  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_miss = 0;

  always #5 clk = ~clk;

  c499 dut (
    .clk_i(clk), .srst_i(srst),
    .N1(d[0]),    .N5(d[1]),    .N9(d[2]),    .N13(d[3]),
    .N17(d[4]),   .N21(d[5]),   .N25(d[6]),   .N29(d[7]),
    .N33(d[8]),   .N37(d[9]),   .N41(d[10]),  .N45(d[11]),
    .N49(d[12]),  .N53(d[13]),  .N57(d[14]),  .N61(d[15]),
    .N65(d[16]),  .N69(d[17]),  .N73(d[18]),  .N77(d[19]),
    .N81(d[20]),  .N85(d[21]),  .N89(d[22]),  .N93(d[23]),
    .N97(d[24]),  .N101(d[25]), .N105(d[26]), .N109(d[27]),
    .N113(d[28]), .N117(d[29]), .N121(d[30]), .N125(d[31]),
    .N129(c[0]), .N130(c[1]), .N131(c[2]), .N132(c[3]),
    .N133(c[4]), .N134(c[5]), .N135(c[6]), .N136(c[7]),
    .N137(e),
    .N724(q[0]),  .N725(q[1]),  .N726(q[2]),  .N727(q[3]),
    .N728(q[4]),  .N729(q[5]),  .N730(q[6]),  .N731(q[7]),
    .N732(q[8]),  .N733(q[9]),  .N734(q[10]), .N735(q[11]),
    .N736(q[12]), .N737(q[13]), .N738(q[14]), .N739(q[15]),
    .N740(q[16]), .N741(q[17]), .N742(q[18]), .N743(q[19]),
    .N744(q[20]), .N745(q[21]), .N746(q[22]), .N747(q[23]),
    .N748(q[24]), .N749(q[25]), .N750(q[26]), .N751(q[27]),
    .N752(q[28]), .N753(q[29]), .N754(q[30]), .N755(q[31])
  );

  // Tracks which output cycles carry an issued vector; reset flushes it like the DUT pipeline.
  always @(posedge clk) begin
    if (srst) vpipe <= '0;
    else      vpipe <= (vpipe << 1) | LAT'(issue_v);
  end

  always @(posedge clk) begin
    #1;
    if (srst) begin
      n_vec++;
      if (q !== 32'h0) begin
        n_miss++;
        $display("FAIL reset: q=%h required=%h", q, 32'h0);
      end else begin
        $display("reset: q=%h ok", q);
      end
      exp_q.delete();
    end else if (vpipe[LAT-1]) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_output: q=%h required=no output", q);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        if (q !== x.exp) begin
          n_miss++;
          $display("FAIL %s: q=%h required=%h", x.name, q, x.exp);
        end else begin
          $display("%s: q=%h ok", x.name, q);
        end
      end
    end
  end

  task automatic apply(input logic [31:0] dv, input logic [7:0] cv, input logic ev,
                       input logic [31:0] expv, input string nm);
    exp_t x;
    @(negedge clk);
    d = dv;
    c = cv;
    e = ev;
    issue_v = 1'b1;
    x.exp = expv;
    x.name = nm;
    exp_q.push_back(x);
  endtask

  initial begin
    // Reset held two cycles with arbitrary inputs.
    d = 32'hDEADBEEF;
    c = 8'h5A;
    e = 1'b1;
    repeat (2) @(negedge clk);
    srst = 1'b0;
    issue_v = 1'b0;

    // Back-to-back vectors, one per cycle.
    apply(32'h00000001, 8'h00, 1'b1, 32'h00000000, "single_d0");
    apply(32'h00000001, 8'h00, 1'b0, 32'h00000001, "corr_disabled");
    apply(32'h00000000, 8'h08, 1'b1, 32'h00000000, "check_bit_err");
    apply(32'h00000003, 8'h00, 1'b1, 32'h00000003, "double_err");
    apply(32'h00000200, 8'h00, 1'b1, 32'h00000000, "bit9");
    apply(32'h00000080, 8'h00, 1'b1, 32'h00000000, "bit7");
    apply(32'h00100000, 8'h00, 1'b1, 32'h00000000, "bit20");
    apply(32'h08000000, 8'h00, 1'b1, 32'h00000000, "bit27");
    apply(32'h80000000, 8'h00, 1'b1, 32'h00000000, "bit31");
    apply(32'h00000000, 8'h81, 1'b1, 32'h00000001, "check_hits_col0");
    apply(32'h00000003, 8'h90, 1'b1, 32'h00000003, "clean_codeword");
    apply(32'hFFFFFFFF, 8'h00, 1'b0, 32'hFFFFFFFF, "ones_disabled");
    apply(32'hFFFFFFFF, 8'h12, 1'b1, 32'hFFFFFDFF, "ones_fix_bit9");
    apply(32'h00000201, 8'h00, 1'b1, 32'h00000201, "two_bytes_err");
    apply(32'h00000000, 8'h00, 1'b1, 32'h00000000, "zero");

    // Reset mid-stream: vector issued then reset asserted with another vector on the inputs.
    apply(32'h00000001, 8'h00, 1'b0, 32'h00000001, "pre_reset");
    @(negedge clk);
    issue_v = 1'b0;
    srst = 1'b1;
    d = 32'hFFFFFFFF;
    c = 8'h00;
    e = 1'b0;
    @(negedge clk);
    srst = 1'b0;

    apply(32'h00000200, 8'h00, 1'b0, 32'h00000200, "post_reset_a");
    apply(32'h00000200, 8'h00, 1'b1, 32'h00000000, "post_reset_b");
    @(negedge clk);
    issue_v = 1'b0;

    // Bounded drain of outstanding expectations.
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && vpipe == '0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: outstanding=%0d required=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
